// File: rtl/accum_readout.sv
// Readout engine: snapshots the packed accumulator sums on start and streams them
// as a framed byte sequence (A5 5A, little-endian points, checksum) over valid/ready.
module accum_readout #(
    parameter int POINTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [29*POINTS-1:0]  sum,
    input  logic                  start,
    output logic                  busy,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  done,
    output logic                  overrun
);

    localparam int PW = (POINTS > 1) ? $clog2(POINTS) : 1;
    localparam logic [PW-1:0] LAST_POINT = PW'(POINTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CSUM
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [POINTS-1:0][28:0]  shadow;
    logic [POINTS-1:0][28:0]  shadow_next;
    logic [PW-1:0]            point_idx;
    logic [PW-1:0]            point_idx_next;
    logic [1:0]               byte_idx;
    logic [1:0]               byte_idx_next;
    logic [7:0]               csum;
    logic [7:0]               csum_next;
    logic [28:0]              cur_point;
    logic [7:0]               tx_data_next;
    logic                     busy_next;
    logic                     tx_valid_next;
    logic                     done_next;
    logic                     overrun_next;
    logic                     xfer;

    assign xfer = tx_valid && tx_ready;

    // State register; the outputs are registered alongside so nothing reaches a port combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            point_idx <= '0;
            byte_idx  <= '0;
            csum      <= '0;
            busy      <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            shadow    <= shadow_next;
            point_idx <= point_idx_next;
            byte_idx  <= byte_idx_next;
            csum      <= csum_next;
            busy      <= busy_next;
            tx_valid  <= tx_valid_next;
            tx_data   <= tx_data_next;
            done      <= done_next;
            overrun   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state;
        shadow_next    = shadow;
        point_idx_next = point_idx;
        byte_idx_next  = byte_idx;
        csum_next      = csum;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = HDR0;
                    shadow_next    = sum;
                    point_idx_next = '0;
                    byte_idx_next  = '0;
                    csum_next      = '0;
                end
            end
            HDR0: if (xfer) state_next = HDR1;
            HDR1: if (xfer) state_next = DATA;
            DATA: begin
                if (xfer) begin
                    csum_next     = csum + tx_data;
                    byte_idx_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (point_idx == LAST_POINT) begin
                            state_next = CSUM;
                        end else begin
                            point_idx_next = point_idx + PW'(1);
                        end
                    end
                end
            end
            CSUM: if (xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are derived from next-cycle state so the byte on tx_data holds steady through stalls.
    always_comb begin
        cur_point     = shadow_next[point_idx_next];
        busy_next     = (state_next != IDLE);
        tx_valid_next = (state_next != IDLE);
        done_next     = (state == CSUM) && xfer;
        overrun_next  = overrun || (start && busy);
        tx_data_next  = 8'h00;
        case (state_next)
            HDR0: tx_data_next = 8'hA5;
            HDR1: tx_data_next = 8'h5A;
            DATA: begin
                case (byte_idx_next)
                    2'd0: tx_data_next = cur_point[7:0];
                    2'd1: tx_data_next = cur_point[15:8];
                    2'd2: tx_data_next = cur_point[23:16];
                    2'd3: tx_data_next = {3'b000, cur_point[28:24]};
                endcase
            end
            CSUM:    tx_data_next = csum_next;
            default: tx_data_next = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_accum_readout.sv
// Scoreboard bench for accum_readout (POINTS=2): expected frames are queued when
// start is driven and popped as bytes transfer on the valid/ready link.
module tb_accum_readout;

    localparam int POINTS = 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [29*POINTS-1:0] sum;
    logic                 start;
    logic                 busy;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 done;
    logic                 overrun;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         xfer_count = 0;
    logic       mon_en = 1'b0;
    logic       pending_done = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] held = 8'h00;

    always #5 clk = ~clk;

    accum_readout #(.POINTS(POINTS)) dut (
        .clk      (clk),
        .rst      (rst),
        .sum      (sum),
        .start    (start),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (done),
        .overrun  (overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Builds the expected frame from the two point values and queues it.
    task automatic pushFrame(input logic [28:0] p0, input logic [28:0] p1);
        logic [28:0] pts [2];
        logic [7:0]  cs;
        logic [7:0]  b;
        pts[0] = p0;
        pts[1] = p1;
        cs = 8'h00;
        sb.push_back('{data: 8'hA5, last: 1'b0});
        sb.push_back('{data: 8'h5A, last: 1'b0});
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                b = (k == 3) ? {3'b000, pts[p][28:24]} : pts[p][8*k +: 8];
                cs = cs + b;
                sb.push_back('{data: b, last: 1'b0});
            end
        end
        sb.push_back('{data: cs, last: 1'b1});
    endtask

    task automatic applyStimulus(input logic [28:0] p0, input logic [28:0] p1);
        sum = {p1, p0};
        start = 1'b1;
        pushFrame(p0, p1);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_valid", {31'd0, tx_valid}, 32'd1);
        checkOutput("start_hdr", {24'd0, tx_data}, 32'hA5);
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
        if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Monitor: samples at negedge so the handshake seen here is what the next posedge will act on.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                checkOutput("done_pulse", {31'd0, done}, {31'd0, pending_done});
                if (pending_done) begin
                    checkOutput("end_busy", {31'd0, busy}, 32'd0);
                    checkOutput("end_valid", {31'd0, tx_valid}, 32'd0);
                end
                pending_done = 1'b0;
                if (prev_stall) begin
                    checkOutput("stall_valid", {31'd0, tx_valid}, 32'd1);
                    checkOutput("stall_data", {24'd0, tx_data}, {24'd0, held});
                end
                if (tx_valid && tx_ready) begin
                    exp_t e;
                    xfer_count++;
                    if (sb.size() == 0) begin
                        checkOutput("extra_xfer", {31'd0, tx_valid}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("byte", {24'd0, tx_data}, {24'd0, e.data});
                        pending_done = e.last;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                held = tx_data;
            end
        end
    end

    initial begin
        int cyc;
        int x0;
        int stall_left;
        logic stalled;

        rst = 1'b1;
        start = 1'b0;
        tx_ready = 1'b1;
        sum = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, tx_data}, 32'h00);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic frame");
        applyStimulus(29'h12345678, 29'h1FFFFFFF);
        waitDone(cyc);
        checkOutput("frame_cycles", cyc, 11);
        @(posedge clk);
        #1;
        checkOutput("basic_idle", {31'd0, busy}, 32'd0);
        checkOutput("basic_sb", sb.size(), 0);

        $display("[TB] backpressure");
        x0 = xfer_count;
        applyStimulus(29'h12345678, 29'h1FFFFFFF);
        stall_left = 0;
        stalled = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (done) break;
            if (stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else if (!stalled && tx_valid && tx_data == 8'h34) begin
                stalled = 1'b1;
                stall_left = 4;
                tx_ready = 1'b0;
            end else begin
                tx_ready = ~tx_ready;
            end
        end
        if (!done) checkOutput("bp_timeout", {31'd0, done}, 32'd1);
        tx_ready = 1'b1;
        checkOutput("bp_xfers", xfer_count - x0, 11);
        checkOutput("bp_sb", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] snapshot");
        applyStimulus(29'h12345678, 29'h1FFFFFFF);
        sum = '1;
        waitDone(cyc);
        checkOutput("snap_sb", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] start while busy");
        applyStimulus(29'h12345678, 29'h1FFFFFFF);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
        waitDone(cyc);
        checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("no_second_busy", {31'd0, busy}, 32'd0);
        checkOutput("no_second_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("ovr_sb", sb.size(), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("overrun_clear", {31'd0, overrun}, 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(29'h12345678, 29'h1FFFFFFF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        pending_done = 1'b0;
        checkOutput("abort_valid", {31'd0, tx_valid}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(29'h12345678, 29'h1FFFFFFF);
        waitDone(cyc);
        checkOutput("restart_cycles", cyc, 11);
        checkOutput("restart_sb", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] zero data back-to-back");
        x0 = xfer_count;
        applyStimulus(29'h0, 29'h0);
        waitDone(cyc);
        applyStimulus(29'h0, 29'h0);
        waitDone(cyc);
        checkOutput("b2b_xfers", xfer_count - x0, 22);
        checkOutput("b2b_overrun", {31'd0, overrun}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_sb", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
